// File: rtl/sa_fifo_serial_tx.sv
// Show-ahead FIFO consumer that serialises each popped word as an async frame:
// start bit, data LSB-first, optional even parity, stop bit.
module sa_fifo_serial_tx #(
  parameter int DataWidth = 8,
  parameter int ClkPerBit = 4,
  parameter int ParityEn  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclr,
  input  logic                 fifo_empty,
  input  logic [DataWidth-1:0] fifo_q,
  output logic                 fifo_ack,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CycW = (ClkPerBit > 1) ? $clog2(ClkPerBit) : 1;
  localparam int BitW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(ClkPerBit - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DataWidth - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic [CycW-1:0]      cyc_cnt, cyc_nxt;
  logic [BitW-1:0]      bit_cnt, bit_nxt;
  logic [DataWidth-1:0] shift, shift_nxt;
  logic                 par, par_nxt;
  logic                 tx_nxt, busy_nxt, done_nxt;
  logic                 cyc_last;

  assign cyc_last = (cyc_cnt == CycLast);

  // Gating by rst_n keeps the FIFO from popping while this block is held in reset.
  assign fifo_ack = (state == IDLE) & ~fifo_empty & ~sclr & rst_n;

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    par_nxt   = par;
    tx_nxt    = tx;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    if (sclr) begin
      state_nxt = IDLE;
      cyc_nxt   = '0;
      bit_nxt   = '0;
      shift_nxt = '0;
      par_nxt   = 1'b0;
      tx_nxt    = 1'b1;
      busy_nxt  = 1'b0;
    end else if (state == IDLE) begin
      tx_nxt = 1'b1;
      if (fifo_ack) begin
        shift_nxt = fifo_q;
        par_nxt   = ^fifo_q;
        state_nxt = START;
        tx_nxt    = 1'b0;
        cyc_nxt   = '0;
        bit_nxt   = '0;
        busy_nxt  = 1'b1;
      end
    end else if (!cyc_last) begin
      cyc_nxt = cyc_cnt + 1'b1;
    end else begin
      // Bit boundary: the next line level is driven on the same edge.
      cyc_nxt = '0;
      case (state)
        START: begin
          state_nxt = DATA;
          bit_nxt   = '0;
          tx_nxt    = shift[0];
        end
        DATA: begin
          if (bit_cnt == BitLast) begin
            bit_nxt = '0;
            if (ParityEn != 0) begin
              state_nxt = PARITY;
              tx_nxt    = par;
            end else begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt   = bit_cnt + 1'b1;
            shift_nxt = shift >> 1;
            tx_nxt    = shift_nxt[0];
          end
        end
        PARITY: begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
        STOP: begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      bit_cnt <= bit_nxt;
      shift   <= shift_nxt;
      par     <= par_nxt;
      tx      <= tx_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sa_fifo_serial_tx.sv
// Directed bench for sa_fifo_serial_tx: a default instance and a parity instance,
// each fed by a small show-ahead FIFO model.
module tb_sa_fifo_serial_tx;

  logic       clk, rst_n, sclr;
  logic       empty0, ack0, tx0, busy0, done0;
  logic [7:0] q0;
  logic       empty1, ack1, tx1, busy1, done1;
  logic [7:0] q1;

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  logic [7:0] mem0 [0:2047];
  logic [7:0] mem1 [0:2047];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

  assign empty0 = (wr0 == rd0);
  assign q0     = mem0[rd0[10:0]];
  assign empty1 = (wr1 == rd1);
  assign q1     = mem1[rd1[10:0]];

  always @(posedge clk) begin
    if (ack0) rd0 <= rd0 + 1;
    if (ack1) rd1 <= rd1 + 1;
  end

  always @(negedge clk)
    if (rst_n && ((ack0 && empty0) || (ack1 && empty1))) viol++;

  sa_fifo_serial_tx #(.DataWidth(8), .ClkPerBit(4), .ParityEn(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .fifo_empty(empty0), .fifo_q(q0),
    .fifo_ack(ack0), .tx(tx0), .busy(busy0), .done(done0)
  );

  sa_fifo_serial_tx #(.DataWidth(8), .ClkPerBit(4), .ParityEn(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclr(sclr), .fifo_empty(empty1), .fifo_q(q1),
    .fifo_ack(ack1), .tx(tx1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int inst, input logic [7:0] w);
    if (inst == 0) begin
      mem0[wr0[10:0]] = w;
      wr0++;
    end else begin
      mem1[wr1[10:0]] = w;
      wr1++;
    end
    #1;
  endtask

  task automatic wait_ack(input int inst, output int ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if ((inst == 0) ? ack0 : ack1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called at the negedge where ack is seen; returns at the last stop-bit cycle.
  task automatic rx_frame(input int inst, output logic [7:0] d, output logic p, output int err);
    int   slots, slot, off;
    logic cur, first;
    slots = (inst == 0) ? 10 : 11;
    d = '0; p = 1'b0; err = 0; first = 1'b0;
    for (int k = 0; k < slots * 4; k++) begin
      @(negedge clk);
      cur = (inst == 0) ? tx0 : tx1;
      if (((inst == 0) ? ack0 : ack1) || !((inst == 0) ? busy0 : busy1) || ((inst == 0) ? done0 : done1))
        err++;
      slot = k / 4;
      off  = k % 4;
      if (off == 0) first = cur;
      else if (cur !== first) err++;
      if (slot == 0 && cur !== 1'b0) err++;
      if (slot == slots - 1 && cur !== 1'b1) err++;
      if (off == 2 && slot >= 1 && slot <= 8) d[slot-1] = cur;
      if (off == 2 && inst == 1 && slot == 9) p = cur;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sclr  = 1'b0;
    repeat (3) @(negedge clk);
    push(0, 8'hA5);
    checks++;
    if ({ack0, tx0, busy0, done0} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL reset_dut0 got ack/tx/busy/done=%b want=0100", {ack0, tx0, busy0, done0});
    end
    checks++;
    if ({ack1, tx1, busy1, done1} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL reset_dut1 got ack/tx/busy/done=%b want=0100", {ack1, tx1, busy1, done1});
    end
  endtask

  task automatic test_single_word();
    logic [9:0] exp_bits;
    exp_bits = 10'b1101001010;
    rst_n = 1'b1;
    #1;
    checks++;
    if (ack0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_ack got=%b want=1", ack0);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (tx0 !== exp_bits[k/4] || busy0 !== 1'b1 || done0 !== 1'b0 || ack0 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL single_cycle%0d got tx/busy/done/ack=%b%b%b%b want=%b100",
                 k + 1, tx0, busy0, done0, ack0, exp_bits[k/4]);
      end
    end
    @(negedge clk);
    checks++;
    if ({tx0, busy0, done0} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL single_done got tx/busy/done=%b want=101", {tx0, busy0, done0});
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done_pulse got=%b want=0", done0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bw [3];
    logic [7:0] d;
    logic       p;
    int         err, ok;
    bw[0] = 8'h00; bw[1] = 8'hFF; bw[2] = 8'h3C;
    push(0, bw[0]); push(0, bw[1]); push(0, bw[2]);
    wait_ack(0, ok);
    checks++;
    if (ok != 1) begin
      errors++;
      $display("[TB] FAIL b2b_first_ack got=timeout want=ack");
    end
    for (int f = 0; f < 3; f++) begin
      rx_frame(0, d, p, err);
      checks++;
      if (d !== bw[f] || err != 0) begin
        errors++;
        $display("[TB] FAIL b2b_frame%0d got=%h err=%0d want=%h err=0", f, d, err, bw[f]);
      end
      @(negedge clk);
      checks++;
      if (done0 !== 1'b1 || ack0 !== (f < 2)) begin
        errors++;
        $display("[TB] FAIL b2b_gap%0d got done/ack=%b%b want=1%b", f, done0, ack0, f < 2);
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("[TB] FAIL ack_while_empty got=%0d want=0", viol);
    end
  endtask

  task automatic test_parity();
    logic [7:0] pw [2];
    logic       pe [2];
    logic [7:0] d;
    logic       p;
    int         err, ok;
    pw[0] = 8'h01; pe[0] = 1'b1;
    pw[1] = 8'h03; pe[1] = 1'b0;
    push(1, pw[0]); push(1, pw[1]);
    wait_ack(1, ok);
    checks++;
    if (ok != 1) begin
      errors++;
      $display("[TB] FAIL parity_first_ack got=timeout want=ack");
    end
    for (int f = 0; f < 2; f++) begin
      rx_frame(1, d, p, err);
      checks++;
      if (d !== pw[f] || p !== pe[f] || err != 0) begin
        errors++;
        $display("[TB] FAIL parity_frame%0d got=%h p=%b err=%0d want=%h p=%b err=0",
                 f, d, p, err, pw[f], pe[f]);
      end
      @(negedge clk);
      checks++;
      if (done1 !== 1'b1 || ack1 !== (f == 0)) begin
        errors++;
        $display("[TB] FAIL parity_gap%0d got done/ack=%b%b want=1%b", f, done1, ack1, f == 0);
      end
    end
  endtask

  task automatic test_empty();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if ({ack0, tx0, busy0, done0} !== 4'b0100) begin
        errors++;
        $display("[TB] FAIL empty_cycle%0d got ack/tx/busy/done=%b want=0100", i, {ack0, tx0, busy0, done0});
      end
    end
  endtask

  task automatic test_sclr();
    logic [7:0] d;
    logic       p;
    int         err, ok;
    push(0, 8'h5A); push(0, 8'hC3);
    wait_ack(0, ok);
    checks++;
    if (ok != 1) begin
      errors++;
      $display("[TB] FAIL sclr_first_ack got=timeout want=ack");
    end
    // 18 cycles in lands inside data bit 3
    repeat (18) @(negedge clk);
    sclr = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({ack0, tx0, busy0, done0} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL sclr_clear got ack/tx/busy/done=%b want=0100", {ack0, tx0, busy0, done0});
    end
    @(negedge clk);
    sclr = 1'b0;
    #1;
    checks++;
    if (ack0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sclr_rearm got ack/done=%b%b want=10", ack0, done0);
    end
    rx_frame(0, d, p, err);
    checks++;
    if (d !== 8'hC3 || err != 0) begin
      errors++;
      $display("[TB] FAIL sclr_next_word got=%h err=%0d want=c3 err=0", d, err);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || ack0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sclr_no_reack got done/ack=%b%b want=10", done0, ack0);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    logic       p;
    int         err, ok;
    push(0, 8'h77); push(0, 8'h88);
    wait_ack(0, ok);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ack0, tx0, busy0, done0} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL async_reset got ack/tx/busy/done=%b want=0100", {ack0, tx0, busy0, done0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ack0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_rearm got=%b want=1", ack0);
    end
    rx_frame(0, d, p, err);
    checks++;
    if (d !== 8'h88 || err != 0) begin
      errors++;
      $display("[TB] FAIL async_next_word got=%h err=%0d want=88 err=0", d, err);
    end
    @(negedge clk);
  endtask

  task automatic test_random_traffic();
    logic [7:0] expq [$];
    logic [7:0] d, w;
    logic       p;
    int         err, ok, pushed, got, np;
    pushed = 0;
    got    = 0;
    while (got < 1000) begin
      np = $urandom_range(0, 2);
      if (wr0 == rd0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (np == 0) np = 1;
      end
      for (int i = 0; i < np && pushed < 1000; i++) begin
        w = 8'($urandom);
        push(0, w);
        expq.push_back(w);
        pushed++;
      end
      wait_ack(0, ok);
      if (ok != 1) begin
        checks++;
        errors++;
        $display("[TB] FAIL random_ack got=timeout want=ack after %0d words", got);
        break;
      end
      rx_frame(0, d, p, err);
      checks++;
      if (d !== expq[0] || err != 0) begin
        errors++;
        $display("[TB] FAIL random_word%0d got=%h err=%0d want=%h err=0", got, d, err, expq[0]);
      end
      expq.pop_front();
      got++;
      @(negedge clk);
      checks++;
      if (done0 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL random_done%0d got=%b want=1", got, done0);
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("[TB] FAIL random_ack_while_empty got=%0d want=0", viol);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_word();
    test_back_to_back();
    test_parity();
    test_empty();
    test_sclr();
    test_async_reset();
    test_random_traffic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sa_fifo_serial_tx.md
Name: sa_fifo_serial_tx

Overview:
Reader-side consumer for the show-ahead single-clock FIFO. It pops words through the FIFO's show-ahead read interface (empty, q, ack) and emits each word as an asynchronous serial frame on a single line: start bit, data LSB-first, optional even parity, stop bit. It sits between the FIFO and a pin or downstream serial link, draining the FIFO at the programmed bit rate.

Parameters:
DataWidth, 8, width of FIFO word and of the serial data field
ClkPerBit, 4, clock cycles per serial bit; must be >= 2
ParityEn, 0, 1 inserts an even-parity bit after the data; 0 omits it

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
sclr  in  1  synchronous clear; same effect as reset, applied at the next rising edge
fifo_empty  in  1  FIFO empty flag; fifo_q is valid only when this is 0
fifo_q  in  DataWidth  show-ahead FIFO head word
fifo_ack  out  1  read-acknowledge to FIFO; pops the head word at the next rising edge
tx  out  1  serial line, idle high; registered
busy  out  1  high while a frame is in progress (state != IDLE); registered
done  out  1  one-cycle pulse in the first IDLE cycle after a stop bit completes; registered

Behaviour:
- Reset (rst_n=0, async) and sclr=1 (sync): state=IDLE, tx=1, busy=0, done=0, bit and cycle counters=0, shift register=0. fifo_ack=0 whenever sclr=1 or rst_n=0. A frame in flight is abandoned with no partial pop; tx returns high at that edge.
- fifo_ack is combinational: fifo_ack = (state==IDLE) & !fifo_empty & !sclr. It is never 1 while fifo_empty=1 and never 1 outside IDLE. Each ack lasts exactly one cycle per frame.
- States: IDLE -> START -> DATA -> (PARITY if ParityEn) -> STOP -> IDLE.
- IDLE: tx=1. If fifo_ack=1, then at the edge: shift<=fifo_q, parity<=^fifo_q, state<=START, tx<=0, cycle counter<=0.
- START, DATA, PARITY, and STOP each hold tx constant for exactly ClkPerBit cycles. The cycle counter counts 0..ClkPerBit-1. On the terminal count, the block advances to the next bit or state and drives the new tx value at the same edge.
- DATA: bit i=0..DataWidth-1 goes out LSB-first. The shift register shifts right at each bit boundary. The bit counter wraps 0..DataWidth-1; after the last bit, the next state is PARITY or STOP.
- PARITY: tx=even parity of the latched word. The total number of 1s in data plus parity is even.
- STOP: tx=1. On the terminal count, state<=IDLE and done<=1 for one cycle.
- Timing: tx falls at the edge that consumes the ack. Frame length = (DataWidth+2+ParityEn)*ClkPerBit cycles. The minimum frame-to-frame period is that value + 1, because one IDLE cycle (the ack cycle) sits between frames. The done pulse and the next ack can share the same IDLE cycle.
- The latched word is immune to changes on fifo_q or fifo_empty after the ack.
- Counters are sized clog2 of their range. There is no overflow; counters wrap only on terminal count.

Test Plan:
- Single word, defaults (DataWidth=8, ClkPerBit=4, ParityEn=0): FIFO holds 8'hA5; release reset -> one ack cycle; tx low 4 cycles, then 1,0,1,0,0,1,0,1 with 4 cycles each, then high 4 cycles; done pulses at cycle 41 after the ack edge; busy high for 40 cycles.
- Back-to-back: FIFO holds 8'h00, 8'hFF, 8'h3C -> 3 acks exactly 41 cycles apart; tx decodes to 00, FF, 3C; fifo_ack never seen with fifo_empty=1.
- Parity (ParityEn=1): words 8'h01 and 8'h03 -> parity bits 1 and 0; frame is 44 cycles, period 45.
- Empty FIFO: fifo_empty=1 held for 200 cycles -> fifo_ack=0, tx=1, busy=0, done=0 throughout.
- sclr mid-frame: assert sclr during DATA bit 3 -> next edge tx=1, busy=0, no done; the following word is re-sent from its start bit after sclr drops; the abandoned word is not re-acked.
- Async reset mid-frame: drop rst_n between clock edges -> tx=1 and busy=0 immediately; random-traffic scoreboard of 1000 words against the golden FIFO model plus a serial decoder shows no loss or reordering.
